// File: rtl/match_run_logger.sv
// Measures runs of consecutive z=1 samples and queues each finished run length
// in a small first-word-fall-through FIFO, with a run counter and sticky drop flag.
//
//   state | meaning
//   IDLE  | waiting for z=1 to start a run
//   RUN   | counting edges with z=1; z=0 closes the run and pushes its length
module match_run_logger #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             z,
  input  logic             rec_ready,
  input  logic             clr_ovf,
  output logic             rec_valid,
  output logic [LEN_W-1:0] rec_len,
  output logic [7:0]       run_count,
  output logic             overflow,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, full, wr_en, drop;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (z)  state_nxt = S_RUN;
      S_RUN:   if (!z) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    push = (state == S_RUN) && !z;
  end

  // A full FIFO still accepts a push when the head is leaving on the same edge.
  assign full      = (count == FULL_CNT);
  assign rec_valid = (count != '0);
  assign pop       = rec_valid && rec_ready;
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign rec_len   = rec_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      len_cnt <= '0;
    end else if (state == S_IDLE && z) begin
      len_cnt <= LEN_W'(1);
    end else if (state == S_RUN && z && len_cnt != LEN_MAX) begin
      len_cnt <= len_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= len_cnt;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A drop on the same edge as clr_ovf wins so no lost record goes unreported.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      run_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push)         run_count <= run_count + 1'b1;
      if (drop)         overflow  <= 1'b1;
      else if (clr_ovf) overflow  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_match_run_logger.sv
// Bench for match_run_logger: directed scenarios plus random traffic, all
// compared against a queue-based model of runs, records and flags.
module tb_match_run_logger;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 8;
  localparam int LEN_SAT = (1 << LEN_W) - 1;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             z, rec_ready, clr_ovf;
  logic             rec_valid;
  logic [LEN_W-1:0] rec_len;
  logic [7:0]       run_count;
  logic             overflow;
  logic             busy;

  match_run_logger #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .z         (z),
    .rec_ready (rec_ready),
    .clr_ovf   (clr_ovf),
    .rec_valid (rec_valid),
    .rec_len   (rec_len),
    .run_count (run_count),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  bit m_in_run;
  int m_len;
  int m_q[$];
  bit m_ovf;
  int m_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_in_run = 0;
    m_len    = 0;
    m_q.delete();
    m_ovf    = 0;
    m_rc     = 0;
  endfunction

  function automatic void m_step(input bit zi, input bit ri, input bit ci);
    bit do_pop, do_push, dropped;
    do_pop  = (m_q.size() > 0) && ri;
    do_push = m_in_run && !zi;
    dropped = 0;
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(m_len);
      else dropped = 1;
      m_rc = (m_rc + 1) % 256;
    end
    if (ci) m_ovf = 0;
    if (dropped) m_ovf = 1;
    if (zi) begin
      m_len    = m_in_run ? ((m_len < LEN_SAT) ? m_len + 1 : LEN_SAT) : 1;
      m_in_run = 1;
    end else begin
      m_in_run = 0;
    end
  endfunction

  task automatic check_all();
    chk("rec_valid", 32'(rec_valid), 32'(m_q.size() != 0));
    chk("rec_len",   32'(rec_len),   (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("run_count", 32'(run_count), 32'(m_rc));
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("busy",      32'(busy),      32'(m_in_run));
  endtask

  // Called at a falling edge; applies inputs across one rising edge.
  task automatic cycle(input bit zi, input bit ri, input bit ci);
    z = zi; rec_ready = ri; clr_ovf = ci;
    m_step(zi, ri, ci);
    @(negedge Clock);
    check_all();
  endtask

  task automatic run_len(input int n, input bit rdy_end);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, rdy_end, 1'b0);
  endtask

  task automatic sync_reset();
    @(negedge Clock);
    Resetn = 1'b0; z = 0; rec_ready = 0; clr_ovf = 0;
    m_reset();
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  initial begin
    Resetn = 1'b0; z = 0; rec_ready = 0; clr_ovf = 0;
    m_reset();
    repeat (2) @(negedge Clock);
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_len",   32'(rec_len),   32'd0);
    chk("rst_rc",    32'(run_count), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    Resetn = 1'b1;

    // single run of 5, record visible one edge after z drops
    run_len(5, 1'b0);
    chk("r032_valid", 32'(rec_valid), 32'd1);
    chk("r032_len",   32'(rec_len),   32'd5);
    chk("r032_rc",    32'(run_count), 32'd1);
    chk("r032_busy",  32'(busy),      32'd0);

    // five runs into a depth-4 FIFO, fifth is dropped
    sync_reset();
    for (int i = 1; i <= 5; i++) run_len(i, 1'b0);
    chk("r033_ovf", 32'(overflow),  32'd1);
    chk("r033_rc",  32'(run_count), 32'd5);
    for (int i = 1; i <= 4; i++) begin
      chk("r033_order", 32'(rec_len), 32'(i));
      cycle(1'b0, 1'b1, 1'b0);
    end
    chk("r033_empty", 32'(rec_valid), 32'd0);
    chk("r033_len0",  32'(rec_len),   32'd0);

    // full FIFO, push with simultaneous pop is accepted
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) run_len(i, 1'b0);
    run_len(7, 1'b1);
    chk("r034_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("r034_valid", 32'(rec_valid), 32'd1);
      if (i == 3) chk("r034_tail", 32'(rec_len), 32'd7);
      cycle(1'b0, 1'b1, 1'b0);
    end
    chk("r034_occ4", 32'(rec_valid), 32'd0);

    // saturation
    run_len(300, 1'b0);
    chk("r035_sat", 32'(rec_len), 32'd255);

    // async reset mid-run at length 3
    cycle(1'b0, 1'b1, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    #2;
    Resetn = 1'b0;
    m_reset();
    #1;
    check_all();
    chk("r036_busy", 32'(busy), 32'd0);
    @(negedge Clock);
    z = 0;
    Resetn = 1'b1;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("r036_norec", 32'(rec_valid), 32'd0);
    chk("r036_rc",    32'(run_count), 32'd0);

    // release with z already high starts a run at length 1
    @(negedge Clock);
    Resetn = 1'b0; z = 1;
    m_reset();
    @(negedge Clock);
    Resetn = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    chk("r031_busy", 32'(busy), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    chk("r031_len", 32'(rec_len), 32'd1);

    // clear overflow without and with a coincident drop
    for (int i = 0; i < 4; i++) run_len(2, 1'b0);
    chk("r037_set", 32'(overflow), 32'd1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("r037_clr", 32'(overflow), 32'd0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("r037_drop_wins", 32'(overflow), 32'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit zr, rr, cr;
      zr = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) == 0);
      cr = ($urandom_range(0, 15) == 0);
      cycle(zr, rr, cr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_run_logger.md
MATCH_RUN_LOGGER -- requirements
Module: match_run_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning record FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter LEN_W, default 8, meaning run-length field width.
REQ-003 SHALL have port Clock  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port z  input  1  match level from the upstream 4-cycle stable-input detector, synchronous to Clock.
REQ-006 SHALL have port rec_ready  input  1  consumer accepts head record when high with rec_valid.
REQ-007 SHALL have port clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-008 SHALL have port rec_valid  output  1  FIFO non-empty; head record presented.
REQ-009 SHALL have port rec_len  output  LEN_W  length in cycles of the head run record.
REQ-010 SHALL have port run_count  output  8  count of completed runs, wraps 255->0.
REQ-011 SHALL have port overflow  output  1  sticky flag: a record was dropped.
REQ-012 SHALL have port busy  output  1  high while in RUN state.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, RUN.
REQ-014 IDLE, z sampled 1: SHALL go to RUN, length counter := 1.
REQ-015 IDLE, z sampled 0: SHALL remain IDLE, length counter unchanged.
REQ-016 RUN, z sampled 1: SHALL remain RUN, length counter += 1, saturating at 2^LEN_W-1.
REQ-017 RUN, z sampled 0: SHALL go to IDLE and in that same edge push the length counter value as one record and increment run_count.
REQ-018 busy SHALL equal (state == RUN).
REQ-019 Run length SHALL equal the number of rising edges at which z was sampled 1 during the run (saturated).
REQ-020 Push latency: rec_valid SHALL be high immediately after the edge that pushes into an empty FIFO (one cycle after z sampled low).
REQ-021 FIFO SHALL be first-word-fall-through: rec_len equals the oldest stored record whenever rec_valid=1; rec_len SHALL be 0 when rec_valid=0.
REQ-022 Pop SHALL occur on an edge where rec_valid=1 and rec_ready=1; rec_ready while empty SHALL have no effect.
REQ-023 Push into a full FIFO with no simultaneous pop SHALL drop the record, set overflow=1, and still increment run_count.
REQ-024 Push into a full FIFO with a simultaneous pop SHALL be accepted: the oldest entry leaves, the new entry is stored, occupancy stays DEPTH, overflow unchanged.
REQ-025 Simultaneous push and pop at any occupancy SHALL keep occupancy unchanged and preserve order.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; occupancy tracked in range 0..DEPTH.
REQ-027 clr_ovf=1 SHALL clear overflow on that edge; a drop on the same edge SHALL take priority (overflow stays 1).
REQ-028 run_count SHALL be 8 bits and wrap from 255 to 0 without flag.

Reset
REQ-029 Resetn low SHALL immediately force: state IDLE, length counter 0, FIFO empty (pointers 0), rec_valid 0, rec_len 0, run_count 0, overflow 0, busy 0.
REQ-030 Reset asserted mid-run SHALL discard the partial run; no record is pushed on release.
REQ-031 After Resetn release with z already 1, the first edge sampling z=1 SHALL start a run (length 1).

Verification
REQ-032 z high for 5 edges then low, rec_ready=0 -> one edge after z low: rec_valid=1, rec_len=5, run_count=1, busy=0.
REQ-033 Five runs of lengths 1,2,3,4,5 with rec_ready=0, DEPTH=4 -> records 1,2,3,4 retained, overflow=1, run_count=5; then rec_ready=1 for 4 edges -> rec_len 1,2,3,4 in order, then rec_valid=0, rec_len=0.
REQ-034 FIFO full, run of length 7 ends on an edge with rec_ready=1 -> occupancy stays 4, overflow stays 0, tail record = 7.
REQ-035 z held high 300 edges, LEN_W=8 -> on end, rec_len=255.
REQ-036 Resetn pulsed low asynchronously during run at length 3 -> outputs at reset values before next edge; no record after release; run_count=0.
REQ-037 overflow=1, clr_ovf=1 on an edge with no drop -> overflow=0; repeat with a simultaneous drop -> overflow=1.
